// File: rtl/alpha_gain_ctrl_if.sv
// Bus between the HDR sample path and the gain-index tracker.
interface alpha_gain_ctrl_if #(
  parameter int DATA_W  = 9,
  parameter int LEVEL_W = 2,
  parameter int TO_W    = 8
);
  logic                      enable;
  logic                      sample_valid;
  logic signed [DATA_W-1:0]  hdr_current_value;
  logic        [DATA_W-1:0]  threshold_high;
  logic        [DATA_W-1:0]  threshold_low;
  logic        [TO_W-1:0]    timeout_cycles;
  logic        [LEVEL_W-1:0] alpha_level;
  logic                      alpha;
  logic                      level_change;
  logic                      sat;
  logic                      cfg_err;

  modport master (
    output enable, sample_valid, hdr_current_value,
           threshold_high, threshold_low, timeout_cycles,
    input  alpha_level, alpha, level_change, sat, cfg_err
  );

  modport slave (
    input  enable, sample_valid, hdr_current_value,
           threshold_high, threshold_low, timeout_cycles,
    output alpha_level, alpha, level_change, sat, cfg_err
  );
endinterface

// File: rtl/alpha_gain_ctrl.sv
// Multi-level HDR gain index tracker: immediate attack with hold-off,
// timed release after consecutive below-threshold samples.
module alpha_gain_ctrl #(
  parameter int DATA_W   = 9,
  parameter int LEVEL_W  = 2,
  parameter int TO_W     = 8,
  parameter int HOLD_CYC = 4
) (
  input logic               clk,
  input logic               reset,
  alpha_gain_ctrl_if.slave  bus
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [LEVEL_W-1:0] MAXL = '1;

  typedef enum logic {TRACK, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mag_q;
  logic                vld_q;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [TO_W-1:0]     rel_q, rel_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                alpha_q;
  logic                lc_q, lc_d;
  logic                sat_q, sat_d;
  logic                cfg_err_q;

  logic [DATA_W-1:0]   raw;
  logic [DATA_W-1:0]   mag_abs;
  logic [TO_W-1:0]     to_eff;
  logic [TO_W-1:0]     rel_inc;

  // Two's complement negate keeps the most negative value as 2^(DATA_W-1).
  assign raw     = bus.hdr_current_value;
  assign mag_abs = raw[DATA_W-1] ? (~raw + DATA_W'(1)) : raw;
  assign to_eff  = (bus.timeout_cycles == '0) ? TO_W'(1) : bus.timeout_cycles;
  assign rel_inc = (rel_q == '1) ? rel_q : rel_q + TO_W'(1);

  // Stage 1: capture sample magnitude and its qualifier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.sample_valid;
      if (bus.sample_valid) mag_q <= mag_abs;
    end
  end

  // Threshold sanity flag, one cycle behind the live thresholds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cfg_err_q <= 1'b0;
    else       cfg_err_q <= (bus.threshold_low > bus.threshold_high);
  end

  // Stage 2 state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TRACK;
      level_q <= '0;
      rel_q   <= '0;
      hold_q  <= '0;
      alpha_q <= 1'b0;
      lc_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      alpha_q <= (level_d != '0);
      lc_q    <= lc_d;
      sat_q   <= sat_d;
    end
  end

  // Stage 2 decision: attack, saturation, release counting and hold-off.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    rel_d   = rel_q;
    hold_d  = hold_q;
    lc_d    = 1'b0;
    sat_d   = 1'b0;
    if (!bus.enable) begin
      state_d = TRACK;
      rel_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        TRACK: begin
          if (cfg_err_q) begin
            rel_d = '0;
          end else if (vld_q) begin
            if (mag_q > bus.threshold_high) begin
              rel_d = '0;
              if (level_q != MAXL) begin
                level_d = level_q + LEVEL_W'(1);
                lc_d    = 1'b1;
                state_d = HOLD;
                hold_d  = HOLD_W'(HOLD_CYC);
              end else begin
                sat_d = 1'b1;
              end
            end else if (mag_q < bus.threshold_low) begin
              // >= rather than == so a lowered timeout fires on the next sample.
              if (rel_inc >= to_eff) begin
                rel_d = '0;
                if (level_q != '0) begin
                  level_d = level_q - LEVEL_W'(1);
                  lc_d    = 1'b1;
                end
              end else begin
                rel_d = rel_inc;
              end
            end else begin
              rel_d = '0;
            end
          end
        end
        HOLD: begin
          rel_d  = '0;
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q <= HOLD_W'(1)) begin
            hold_d  = '0;
            state_d = TRACK;
          end
        end
        default: state_d = TRACK;
      endcase
    end
  end

  assign bus.alpha_level  = level_q;
  assign bus.alpha        = alpha_q;
  assign bus.level_change = lc_q;
  assign bus.sat          = sat_q;
  assign bus.cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_alpha_gain_ctrl.sv
// Bench for alpha_gain_ctrl: per-cycle reference model feeding a scoreboard,
// plus directed timing checks for attack, release, enable and config errors.
module tb_alpha_gain_ctrl;
  localparam int DATA_W   = 9;
  localparam int LEVEL_W  = 2;
  localparam int TO_W     = 8;
  localparam int HOLD_CYC = 4;
  localparam int MAXL     = (1 << LEVEL_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alpha_gain_ctrl_if #(.DATA_W(DATA_W), .LEVEL_W(LEVEL_W), .TO_W(TO_W)) bus ();

  alpha_gain_ctrl #(
    .DATA_W(DATA_W), .LEVEL_W(LEVEL_W), .TO_W(TO_W), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int lvl;
    bit lc;
    bit sat;
    bit alpha;
    bit cfg;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Live configuration driven onto the bus each cycle.
  int th   = 200;
  int tl   = 50;
  int tmo  = 10;
  bit en   = 1'b1;

  // Reference model state.
  int m_lvl, m_cnt, m_hold, m_mag;
  bit m_vld, m_cfg;

  task automatic model_clear();
    m_lvl = 0; m_cnt = 0; m_hold = 0; m_mag = 0;
    m_vld = 1'b0; m_cfg = 1'b0;
    sb.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    bus.hdr_current_value = '0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: drive inputs, predict outputs of this edge, then compare.
  task automatic cycle(input bit v, input int x);
    exp_t e;
    bit   lc, st;
    int   tgt;
    bus.enable            = en;
    bus.sample_valid      = v;
    bus.hdr_current_value = DATA_W'(x);
    bus.threshold_high    = DATA_W'(th);
    bus.threshold_low     = DATA_W'(tl);
    bus.timeout_cycles    = TO_W'(tmo);
    lc = 1'b0; st = 1'b0;
    if (!en) begin
      m_hold = 0; m_cnt = 0;
    end else if (m_hold > 0) begin
      m_hold--; m_cnt = 0;
    end else if (m_cfg) begin
      m_cnt = 0;
    end else if (m_vld) begin
      if (m_mag > th) begin
        m_cnt = 0;
        if (m_lvl < MAXL) begin m_lvl++; lc = 1'b1; m_hold = HOLD_CYC; end
        else st = 1'b1;
      end else if (m_mag < tl) begin
        m_cnt++;
        tgt = (tmo == 0) ? 1 : tmo;
        if (m_cnt >= tgt) begin
          m_cnt = 0;
          if (m_lvl > 0) begin m_lvl--; lc = 1'b1; end
        end
      end else begin
        m_cnt = 0;
      end
    end
    m_cfg = (tl > th);
    m_vld = v;
    if (v) m_mag = (x < 0) ? -x : x;
    e.lvl = m_lvl; e.lc = lc; e.sat = st; e.alpha = (m_lvl != 0); e.cfg = m_cfg;
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      failures++; checks++;
      $display("FAIL sb_empty t=%0t", $time);
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.alpha_level !== LEVEL_W'(e.lvl)) begin
        failures++;
        $display("FAIL sb_level t=%0t got=%0d exp=%0d", $time, bus.alpha_level, e.lvl);
      end
      checks++;
      if (bus.level_change !== e.lc) begin
        failures++;
        $display("FAIL sb_level_change t=%0t got=%b exp=%b", $time, bus.level_change, e.lc);
      end
      checks++;
      if (bus.sat !== e.sat) begin
        failures++;
        $display("FAIL sb_sat t=%0t got=%b exp=%b", $time, bus.sat, e.sat);
      end
      checks++;
      if (bus.alpha !== e.alpha) begin
        failures++;
        $display("FAIL sb_alpha t=%0t got=%b exp=%b", $time, bus.alpha, e.alpha);
      end
      checks++;
      if (bus.cfg_err !== e.cfg) begin
        failures++;
        $display("FAIL sb_cfg_err t=%0t got=%b exp=%b", $time, bus.cfg_err, e.cfg);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.alpha_level, bus.alpha, bus.level_change, bus.sat, bus.cfg_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {bus.alpha_level, bus.alpha, bus.level_change, bus.sat, bus.cfg_err});
    end
    apply_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 100);
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== '0) begin
      failures++;
      $display("FAIL inband_level got=%0d exp=0", bus.alpha_level);
    end
  endtask

  task automatic test_attack();
    int lc_at[$];
    int nsat;
    nsat = 0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 210);
      if (bus.level_change === 1'b1) lc_at.push_back(i);
      if (bus.sat === 1'b1) nsat++;
    end
    checks++;
    if (lc_at.size() != 3) begin
      failures++;
      $display("FAIL attack_steps got=%0d exp=3", lc_at.size());
    end else begin
      checks++;
      if (lc_at[0] != 1 || lc_at[1] != 6 || lc_at[2] != 11) begin
        failures++;
        $display("FAIL attack_edges got=%0d,%0d,%0d exp=1,6,11", lc_at[0], lc_at[1], lc_at[2]);
      end
    end
    checks++;
    if (nsat != 4) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=4", nsat);
    end
    // Reset asserted mid-cycle must clear outputs before the next edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.alpha_level, bus.alpha, bus.level_change, bus.sat} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=0",
               {bus.alpha_level, bus.alpha, bus.level_change, bus.sat});
    end
    apply_reset();
  endtask

  task automatic test_negative();
    apply_reset();
    cycle(1'b1, -205);
    for (int i = 0; i < 5; i++) cycle(1'b1, 100);
    cycle(1'b1, -256);
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== LEVEL_W'(2)) begin
      failures++;
      $display("FAIL neg_attack got=%0d exp=2", bus.alpha_level);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 0);
    for (int i = 0; i < 9; i++) cycle(1'b1, -12);
    cycle(1'b1, 200);
    for (int i = 0; i < 9; i++) cycle(1'b1, -12);
    cycle(1'b1, 50);
    for (int i = 0; i < 9; i++) cycle(1'b1, -12);
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== LEVEL_W'(2)) begin
      failures++;
      $display("FAIL band_clears got=%0d exp=2", bus.alpha_level);
    end
    cycle(1'b1, -12);
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== LEVEL_W'(1)) begin
      failures++;
      $display("FAIL neg_release got=%0d exp=1", bus.alpha_level);
    end
  endtask

  task automatic test_release();
    int lvl_at[80];
    int ndown;
    ndown = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 210);
    for (int s = 0; s < 80; s++) begin
      cycle((s % 5) != 4, (s == 7) ? 70 : 40);
      lvl_at[s] = int'(bus.alpha_level);
      if (bus.level_change === 1'b1) ndown++;
    end
    checks++;
    if (lvl_at[20] != 3) begin
      failures++;
      $display("FAIL release_restart got=%0d exp=3", lvl_at[20]);
    end
    checks++;
    if (lvl_at[21] != 2) begin
      failures++;
      $display("FAIL release_first got=%0d exp=2", lvl_at[21]);
    end
    checks++;
    if (ndown != 3 || bus.alpha_level !== '0) begin
      failures++;
      $display("FAIL release_total got=%0d/%0d exp=3/0", ndown, bus.alpha_level);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    cycle(1'b1, 210);
    for (int i = 0; i < 5; i++) cycle(1'b1, 100);
    for (int i = 0; i < 6; i++) cycle(1'b1, 40);
    cycle(1'b0, 0);
    en = 1'b0;
    cycle(1'b0, 0);
    cycle(1'b1, 250);
    cycle(1'b0, 0);
    en = 1'b1;
    checks++;
    if (bus.alpha_level !== LEVEL_W'(1)) begin
      failures++;
      $display("FAIL enable_frozen got=%0d exp=1", bus.alpha_level);
    end
    for (int i = 0; i < 9; i++) cycle(1'b1, 40);
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== LEVEL_W'(1)) begin
      failures++;
      $display("FAIL enable_fresh got=%0d exp=1", bus.alpha_level);
    end
    cycle(1'b1, 40);
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== '0) begin
      failures++;
      $display("FAIL enable_step got=%0d exp=0", bus.alpha_level);
    end
    // Zero timeout behaves as one: a step per below-low sample.
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 210);
      for (int i = 0; i < 5; i++) cycle(1'b1, 100);
    end
    tmo = 0;
    cycle(1'b1, 40);
    cycle(1'b1, 40);
    checks++;
    if (bus.alpha_level !== LEVEL_W'(1)) begin
      failures++;
      $display("FAIL tmo0_first got=%0d exp=1", bus.alpha_level);
    end
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== '0) begin
      failures++;
      $display("FAIL tmo0_second got=%0d exp=0", bus.alpha_level);
    end
    tmo = 10;
  endtask

  task automatic test_cfg_err();
    apply_reset();
    cycle(1'b1, 210);
    for (int i = 0; i < 5; i++) cycle(1'b1, 100);
    tl = 210;
    cycle(1'b0, 0);
    checks++;
    if (bus.cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL cfg_err_set got=%b exp=1", bus.cfg_err);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 250);
    for (int i = 0; i < 12; i++) cycle(1'b1, 10);
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== LEVEL_W'(1)) begin
      failures++;
      $display("FAIL cfg_err_hold got=%0d exp=1", bus.alpha_level);
    end
    tl = 50;
    cycle(1'b0, 0);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL cfg_err_clear got=%b exp=0", bus.cfg_err);
    end
    cycle(1'b1, 250);
    cycle(1'b0, 0);
    checks++;
    if (bus.alpha_level !== LEVEL_W'(2)) begin
      failures++;
      $display("FAIL cfg_resume got=%0d exp=2", bus.alpha_level);
    end
  endtask

  initial begin
    bus.enable            = 1'b1;
    bus.sample_valid      = 1'b0;
    bus.hdr_current_value = '0;
    bus.threshold_high    = DATA_W'(th);
    bus.threshold_low     = DATA_W'(tl);
    bus.timeout_cycles    = TO_W'(tmo);
    reset                 = 1'b0;
    model_clear();
    test_reset();
    test_attack();
    test_negative();
    test_release();
    test_enable();
    test_cfg_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t exceeded time limit", $time);
    $fatal(1);
  end

endmodule
